// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: dispatch/CDB/query/retire bundle between the ROB and its pipeline neighbours.
interface reorder_buffer_if #(
  parameter int ROB_SIZE = 8,
  parameter int TAG_W    = $clog2(ROB_SIZE) + 1,
  parameter int REG_SIZE = 32,
  parameter int XLEN     = 32
);
  localparam int RW = $clog2(REG_SIZE);
  logic             dispatch_enable;
  logic [RW-1:0]    rd_dispatch;
  logic [TAG_W-1:0] CDB_tag;
  logic [XLEN-1:0]  CDB_value;
  logic             CDB_mispredict;
  logic [TAG_W-1:0] rs1_query_tag;
  logic [TAG_W-1:0] rs2_query_tag;
  logic [TAG_W-1:0] rob_tail;
  logic             full;
  logic             clear;
  logic [RW-1:0]    rd_retire;
  logic [XLEN-1:0]  retire_value;
  logic             squash;
  logic             rs1_ready;
  logic [XLEN-1:0]  rs1_value;
  logic             rs2_ready;
  logic [XLEN-1:0]  rs2_value;
  modport master (
    output dispatch_enable, rd_dispatch, CDB_tag, CDB_value, CDB_mispredict,
           rs1_query_tag, rs2_query_tag,
    input  rob_tail, full, clear, rd_retire, retire_value, squash,
           rs1_ready, rs1_value, rs2_ready, rs2_value
  );
  modport slave (
    input  dispatch_enable, rd_dispatch, CDB_tag, CDB_value, CDB_mispredict,
           rs1_query_tag, rs2_query_tag,
    output rob_tail, full, clear, rd_retire, retire_value, squash,
           rs1_ready, rs1_value, rs2_ready, rs2_value
  );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: single-issue ROB; allocates tags at dispatch, records CDB results, retires in order.
module reorder_buffer #(
  parameter int ROB_SIZE = 8,
  parameter int TAG_W    = $clog2(ROB_SIZE) + 1,
  parameter int REG_SIZE = 32,
  parameter int XLEN     = 32
) (
  input logic clock,
  input logic reset,
  reorder_buffer_if.slave bus
);
  localparam int PW = $clog2(ROB_SIZE);
  localparam int RW = $clog2(REG_SIZE);
  logic [ROB_SIZE-1:0] valid_q, complete_q, mispred_q;
  logic [RW-1:0]       rd_q    [ROB_SIZE];
  logic [XLEN-1:0]     value_q [ROB_SIZE];
  logic [PW-1:0]       head_q, tail_q, head_d, tail_d, cdb_slot;
  logic [PW:0]         count_q, count_d;
  logic                full, clear, squash, dispatch_ok, cdb_hit;
  logic [XLEN:0]       q1, q2;
  // Forwarding from the CDB beats the stored state; non-ready slots read as zero.
  function automatic logic [XLEN:0] lookup(input logic [TAG_W-1:0] t,
                                           input logic [TAG_W-1:0] ct,
                                           input logic [XLEN-1:0] cv);
    logic [PW-1:0] s;
    s = PW'(t - 1'b1);
    if (t == '0 || t > TAG_W'(ROB_SIZE)) return '0;
    if (t == ct) return {1'b1, cv};
    return (valid_q[s] && complete_q[s]) ? {1'b1, value_q[s]} : '0;
  endfunction
  always_comb begin
    full        = count_q == (PW+1)'(ROB_SIZE);
    clear       = valid_q[head_q] && complete_q[head_q];
    squash      = clear && mispred_q[head_q];
    dispatch_ok = bus.dispatch_enable && !full && !squash;
    cdb_slot    = PW'(bus.CDB_tag - 1'b1);
    cdb_hit     = bus.CDB_tag != '0 && bus.CDB_tag <= TAG_W'(ROB_SIZE) && valid_q[cdb_slot];
    head_d      = head_q + PW'(clear);
    tail_d      = tail_q + PW'(dispatch_ok);
    count_d     = count_q + (PW+1)'(dispatch_ok) - (PW+1)'(clear);
    q1          = lookup(bus.rs1_query_tag, bus.CDB_tag, bus.CDB_value);
    q2          = lookup(bus.rs2_query_tag, bus.CDB_tag, bus.CDB_value);
  end
  assign bus.rob_tail     = TAG_W'(tail_q) + TAG_W'(1);
  assign bus.full         = full;
  assign bus.clear        = clear;
  assign bus.squash       = squash;
  assign bus.rd_retire    = clear ? rd_q[head_q] : '0;
  assign bus.retire_value = clear ? value_q[head_q] : '0;
  assign {bus.rs1_ready, bus.rs1_value} = q1;
  assign {bus.rs2_ready, bus.rs2_value} = q2;
  // A squash behaves like reset: same-cycle dispatch and CDB writes are dropped.
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      valid_q    <= '0;
      complete_q <= '0;
      mispred_q  <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (dispatch_ok) begin
        valid_q[tail_q]    <= 1'b1;
        complete_q[tail_q] <= 1'b0;
        mispred_q[tail_q]  <= 1'b0;
        rd_q[tail_q]       <= bus.rd_dispatch;
      end
      if (cdb_hit) begin
        complete_q[cdb_slot] <= 1'b1;
        mispred_q[cdb_slot]  <= bus.CDB_mispredict;
        value_q[cdb_slot]    <= bus.CDB_value;
      end
      if (clear) valid_q[head_q] <= 1'b0;
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed stimulus with a retire scoreboard checked by an independent monitor.
module tb_reorder_buffer;
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    logic        sq;
  } ret_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  ret_t exp_q[$];
  reorder_buffer_if bus_if ();
  reorder_buffer dut (.clock(clk), .reset(rst), .bus(bus_if));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic de, input logic [4:0] rd, input logic [3:0] tag,
                       input logic [31:0] val, input logic mp,
                       input logic [3:0] t1, input logic [3:0] t2);
    bus_if.dispatch_enable = de;
    bus_if.rd_dispatch     = rd;
    bus_if.CDB_tag         = tag;
    bus_if.CDB_value       = val;
    bus_if.CDB_mispredict  = mp;
    bus_if.rs1_query_tag   = t1;
    bus_if.rs2_query_tag   = t2;
    #1;
  endtask
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [4:0] rd, input logic [31:0] val, input logic sq);
    ret_t e;
    e.rd = rd; e.val = val; e.sq = sq;
    exp_q.push_back(e);
  endtask
  always @(negedge clk) begin
    if (!rst && bus_if.clear) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_retire: got clear=1 rd=%0d expected no retire at %0t", bus_if.rd_retire, $time);
      end else begin
        ret_t e;
        e = exp_q.pop_front();
        chk("retire_rd", 32'(bus_if.rd_retire), 32'(e.rd));
        chk("retire_value", bus_if.retire_value, e.val);
        chk("retire_squash", 32'(bus_if.squash), 32'(e.sq));
      end
    end else if (!rst && bus_if.squash) begin
      checks++;
      failures++;
      $display("FAIL squash_without_clear: got squash=1 expected 0 at %0t", $time);
    end
  end
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    nxt; nxt;
    rst = 1'b0;
    // 1: post-reset idle
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("reset_rob_tail", 32'(bus_if.rob_tail), 1);
    chk("reset_full", 32'(bus_if.full), 0);
    chk("reset_clear", 32'(bus_if.clear), 0);
    chk("reset_squash", 32'(bus_if.squash), 0);
    chk("reset_rs1_ready", 32'(bus_if.rs1_ready), 0);
    nxt;
    // 2: dispatch two entries
    drive(1, 15, 0, 0, 0, 0, 0);
    chk("disp1_tag", 32'(bus_if.rob_tail), 1);
    nxt;
    drive(1, 11, 0, 0, 0, 0, 0);
    chk("disp2_tag", 32'(bus_if.rob_tail), 2);
    nxt;
    drive(0, 0, 0, 0, 0, 2, 0);
    chk("after_disp_tail", 32'(bus_if.rob_tail), 3);
    chk("after_disp_clear", 32'(bus_if.clear), 0);
    chk("q2_not_ready", 32'(bus_if.rs1_ready), 0);
    nxt;
    // 3: out-of-order completion, in-order retire
    drive(0, 0, 2, 32'hAB, 0, 2, 0);
    chk("fwd_ready", 32'(bus_if.rs1_ready), 1);
    chk("fwd_value", bus_if.rs1_value, 32'hAB);
    chk("ooo_no_clear", 32'(bus_if.clear), 0);
    nxt;
    push(15, 32'h5, 0);
    push(11, 32'hAB, 0);
    drive(0, 0, 1, 32'h5, 0, 2, 1);
    chk("stored_ready", 32'(bus_if.rs1_ready), 1);
    chk("stored_value", bus_if.rs1_value, 32'hAB);
    chk("fwd2_value", bus_if.rs2_value, 32'h5);
    chk("same_cycle_no_clear", 32'(bus_if.clear), 0);
    nxt;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("retire1_clear", 32'(bus_if.clear), 1);
    nxt;
    chk("retire2_clear", 32'(bus_if.clear), 1);
    nxt;
    chk("drained_clear", 32'(bus_if.clear), 0);
    nxt;
    // 4: fill from tail=2, overflow attempt, free one slot
    for (int i = 0; i < 8; i++) begin
      drive(1, 5'(i + 1), 0, 0, 0, 0, 0);
      chk("fill_tag", 32'(bus_if.rob_tail), ((2 + i) % 8) + 1);
      chk("fill_not_full", 32'(bus_if.full), 0);
      nxt;
    end
    drive(1, 20, 0, 0, 0, 0, 0);
    chk("full_set", 32'(bus_if.full), 1);
    chk("full_tail", 32'(bus_if.rob_tail), 3);
    nxt;
    push(1, 32'h33, 0);
    drive(0, 0, 3, 32'h33, 0, 0, 0);
    chk("still_full", 32'(bus_if.full), 1);
    chk("dropped_tail", 32'(bus_if.rob_tail), 3);
    nxt;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("full_during_retire", 32'(bus_if.full), 1);
    nxt;
    chk("freed_full", 32'(bus_if.full), 0);
    chk("freed_tail", 32'(bus_if.rob_tail), 3);
    // 6: reset mid-operation with a pending CDB write
    rst = 1'b1;
    drive(1, 3, 4, 32'h44, 0, 0, 0);
    nxt;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 4, 3);
    chk("rst2_rob_tail", 32'(bus_if.rob_tail), 1);
    chk("rst2_full", 32'(bus_if.full), 0);
    chk("rst2_clear", 32'(bus_if.clear), 0);
    chk("rst2_squash", 32'(bus_if.squash), 0);
    chk("rst2_rd_retire", 32'(bus_if.rd_retire), 0);
    chk("rst2_retire_value", bus_if.retire_value, 0);
    chk("rst2_rs1_ready", 32'(bus_if.rs1_ready), 0);
    chk("rst2_rs1_value", bus_if.rs1_value, 0);
    chk("rst2_rs2_ready", 32'(bus_if.rs2_ready), 0);
    nxt;
    // 5: mispredict squash
    for (int i = 1; i <= 3; i++) begin
      drive(1, 5'(i), 0, 0, 0, 0, 0);
      chk("sq_disp_tag", 32'(bus_if.rob_tail), i);
      nxt;
    end
    push(1, 32'h99, 1);
    drive(0, 0, 1, 32'h99, 1, 0, 0);
    chk("sq_pre_clear", 32'(bus_if.clear), 0);
    nxt;
    drive(1, 7, 2, 32'h22, 0, 0, 0);
    chk("sq_squash", 32'(bus_if.squash), 1);
    nxt;
    drive(0, 0, 0, 0, 0, 2, 3);
    chk("sq_rob_tail", 32'(bus_if.rob_tail), 1);
    chk("sq_full", 32'(bus_if.full), 0);
    chk("sq_clear", 32'(bus_if.clear), 0);
    chk("sq_q2_ready", 32'(bus_if.rs1_ready), 0);
    chk("sq_q3_ready", 32'(bus_if.rs2_ready), 0);
    nxt;
    drive(1, 9, 0, 0, 0, 0, 0);
    chk("post_sq_tag", 32'(bus_if.rob_tail), 1);
    nxt;
    push(9, 32'h77, 0);
    drive(0, 0, 1, 32'h77, 0, 0, 0);
    nxt;
    drive(0, 0, 0, 0, 0, 0, 0);
    nxt;
    nxt;
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
